// File: rtl/maxpool_2x2_if.sv
// rtl/maxpool_2x2_if.sv - pixel stream bundle between conv, maxpool_2x2 and the next layer
interface maxpool_2x2_if #(
  parameter int NUM_FEATURE_MAPS = 6,
  parameter int DATA_W           = 16
);
  logic                                     i_feature_valid;
  logic [0:NUM_FEATURE_MAPS-1][DATA_W-1:0]  i_features;
  logic                                     o_feature_valid;
  logic [0:NUM_FEATURE_MAPS-1][DATA_W-1:0]  o_features;
  logic                                     o_frame_done;

  // Stimulus / upstream side
  modport master (
    output i_feature_valid, i_features,
    input  o_feature_valid, o_features, o_frame_done
  );

  // Pooling block side
  modport slave (
    input  i_feature_valid, i_features,
    output o_feature_valid, o_features, o_frame_done
  );
endinterface

// File: rtl/maxpool_2x2.sv
// rtl/maxpool_2x2.sv - 2x2 stride-2 signed max pooling over NUM_FEATURE_MAPS parallel maps (optional POOL_RELU_EN input clamp)
module maxpool_2x2 #(
  parameter int NUM_FEATURE_MAPS = 6,
  parameter int DATA_W           = 16,
  parameter int IN_W             = 28,
  parameter int IN_H             = 28
) (
  input  logic          i_clk,
  input  logic          i_rst,
  maxpool_2x2_if.slave  io_bus
);

  localparam int COL_W  = $clog2(IN_W);
  localparam int ROW_W  = $clog2(IN_H);
  localparam int HALF_W = IN_W / 2;

  typedef enum logic {EVEN_ROW = 1'b0, ODD_ROW = 1'b1} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [COL_W-1:0]           r_col;
  logic [ROW_W-1:0]           r_row;
  logic                       w_accept;
  logic                       w_odd_col;
  logic                       w_last_col;
  logic                       w_last_row;
  logic [COL_W-2:0]           w_lb_idx;

  logic signed [DATA_W-1:0]   w_x      [NUM_FEATURE_MAPS];
  logic signed [DATA_W-1:0]   r_hreg   [NUM_FEATURE_MAPS];
  logic signed [DATA_W-1:0]   w_h      [NUM_FEATURE_MAPS];
  logic signed [DATA_W-1:0]   w_pool   [NUM_FEATURE_MAPS];
  logic signed [DATA_W-1:0]   r_linebuf[HALF_W][NUM_FEATURE_MAPS];

  logic                                     r_o_valid;
  logic                                     r_o_done;
  logic [0:NUM_FEATURE_MAPS-1][DATA_W-1:0]  r_o_features;

  assign w_accept   = io_bus.i_feature_valid;
  assign w_odd_col  = r_col[0];
  assign w_last_col = (r_col == COL_W'(IN_W - 1));
  assign w_last_row = (r_row == ROW_W'(IN_H - 1));
  assign w_lb_idx   = r_col[COL_W-1:1];

  assign io_bus.o_feature_valid = r_o_valid;
  assign io_bus.o_frame_done    = r_o_done;
  assign io_bus.o_features      = r_o_features;

  // Per-map sample conditioning, horizontal pair max and vertical window max
  always_comb begin
    for (int m = 0; m < NUM_FEATURE_MAPS; m++) begin
      w_x[m] = $signed(io_bus.i_features[m]);
`ifdef POOL_RELU_EN
      if (w_x[m][DATA_W-1]) begin
        w_x[m] = '0;
      end
`endif
      w_h[m]    = (w_x[m] > r_hreg[m]) ? w_x[m] : r_hreg[m];
      w_pool[m] = (r_linebuf[w_lb_idx][m] > w_h[m]) ? r_linebuf[w_lb_idx][m] : w_h[m];
    end
  end

  // Row parity flips when the last column of a row is accepted
  always_comb begin
    w_state_next = r_state;
    if (w_accept && w_last_col) begin
      case (r_state)
        EVEN_ROW: w_state_next = ODD_ROW;
        ODD_ROW:  w_state_next = EVEN_ROW;
        default:  w_state_next = EVEN_ROW;
      endcase
    end
  end

  // Raster position, parity state and the even-column holding register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= EVEN_ROW;
      r_col   <= '0;
      r_row   <= '0;
      for (int m = 0; m < NUM_FEATURE_MAPS; m++) begin
        r_hreg[m] <= '0;
      end
    end else if (w_accept) begin
      r_state <= w_state_next;
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (!w_odd_col) begin
        for (int m = 0; m < NUM_FEATURE_MAPS; m++) begin
          r_hreg[m] <= w_x[m];
        end
      end
    end
  end

  // Line buffer holds each top-row pair max until the matching bottom-row pair arrives
  always_ff @(posedge i_clk) begin
    if (w_accept && w_odd_col && (r_state == EVEN_ROW)) begin
      for (int m = 0; m < NUM_FEATURE_MAPS; m++) begin
        r_linebuf[w_lb_idx][m] <= w_h[m];
      end
    end
  end

  // Pooled output register and strobes; features hold between strobes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_o_valid    <= 1'b0;
      r_o_done     <= 1'b0;
      r_o_features <= '0;
    end else begin
      r_o_valid <= 1'b0;
      r_o_done  <= 1'b0;
      if (w_accept && w_odd_col && (r_state == ODD_ROW)) begin
        r_o_valid <= 1'b1;
        r_o_done  <= w_last_row && w_last_col;
        for (int m = 0; m < NUM_FEATURE_MAPS; m++) begin
          r_o_features[m] <= w_pool[m];
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
// tb/tb_maxpool_2x2.sv - self-checking bench for maxpool_2x2 against a whole-frame window model
module tb_maxpool_2x2;
  localparam int N  = 6;
  localparam int W  = 16;
  localparam int IW = 28;
  localparam int IH = 28;
  localparam int POOLED = (IW / 2) * (IH / 2);

  typedef logic [0:N-1][W-1:0] pix_t;
  typedef struct {
    int   cyc;
    pix_t data;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   dones  = 0;
  exp_t q[$];
  logic signed [W-1:0] frm [IH][IW][N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool_2x2_if #(.NUM_FEATURE_MAPS(N), .DATA_W(W)) bus ();

  maxpool_2x2 #(
    .NUM_FEATURE_MAPS(N), .DATA_W(W), .IN_W(IW), .IN_H(IH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  function automatic logic signed [W-1:0] clampv(input logic signed [W-1:0] x);
`ifdef POOL_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic signed [W-1:0] pix_val(input int mode, input int r, input int c, input int m);
    int corner;
    corner = (r % 2) * 2 + (c % 2);
    case (mode)
      0: return 16'sd40;
      1: return 16'sd41;
      2: return (corner == (m % 4)) ? 16'sd500 : 16'sd1;
      3: begin
        if (m != 0) return W'($urandom);
        case (corner)
          0: return -16'sd3;
          1: return -16'sd7;
          2: return -16'sd1;
          default: return -16'sd20;
        endcase
      end
      default: return W'($urandom);
    endcase
  endfunction

  function automatic pix_t window_max(input int r, input int c);
    pix_t res;
    for (int m = 0; m < N; m++) begin
      int best;
      best = clampv(frm[r-1][c-1][m]);
      if (int'(clampv(frm[r-1][c][m])) > best) best = clampv(frm[r-1][c][m]);
      if (int'(clampv(frm[r][c-1][m]))  > best) best = clampv(frm[r][c-1][m]);
      if (int'(clampv(frm[r][c][m]))    > best) best = clampv(frm[r][c][m]);
      res[m] = W'(best);
    end
    return res;
  endfunction

  // Compares every pulse against the expected-output queue
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_v;
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      if (bus.o_feature_valid || bus.o_frame_done || exp_v) begin
        checks++;
        assert (bus.o_feature_valid === exp_v)
          else begin errors++; $error("FAIL valid_timing cyc=%0d got %b exp %b", cyc, bus.o_feature_valid, exp_v); end
        if (exp_v) begin
          checks++;
          assert (bus.o_features === q[0].data)
            else begin errors++; $error("FAIL pooled_data cyc=%0d got %h exp %h", cyc, bus.o_features, q[0].data); end
          checks++;
          assert (bus.o_frame_done === q[0].done)
            else begin errors++; $error("FAIL frame_done cyc=%0d got %b exp %b", cyc, bus.o_frame_done, q[0].done); end
          void'(q.pop_front());
        end else begin
          checks++;
          assert (bus.o_frame_done === 1'b0)
            else begin errors++; $error("FAIL stray_done cyc=%0d got %b exp 0", cyc, bus.o_frame_done); end
        end
        if (bus.o_feature_valid) pulses++;
        if (bus.o_frame_done) dones++;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.i_feature_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int mode, input int gap_max, input int npix);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        for (int m = 0; m < N; m++)
          frm[r][c][m] = pix_val(mode, r, c, m);
    for (int idx = 0; idx < npix; idx++) begin
      int r;
      int c;
      r = idx / IW;
      c = idx % IW;
      if (gap_max > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap_max));
      @(posedge clk); #1;
      bus.i_feature_valid = 1'b1;
      for (int m = 0; m < N; m++) bus.i_features[m] = frm[r][c][m];
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = window_max(r, c);
        e.done = (r == IH - 1) && (c == IW - 1);
        q.push_back(e);
      end
    end
    idle(1);
  endtask

  task automatic drain_and_count(input string tag, input int exp_pulses, input int exp_dones);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    idle(2);
    checks++;
    assert (q.size() == 0)
      else begin errors++; $error("FAIL %s_missing got %0d pending exp 0", tag, q.size()); end
    checks++;
    assert (pulses == exp_pulses)
      else begin errors++; $error("FAIL %s_pulses got %0d exp %0d", tag, pulses, exp_pulses); end
    checks++;
    assert (dones == exp_dones)
      else begin errors++; $error("FAIL %s_dones got %0d exp %0d", tag, dones, exp_dones); end
    pulses = 0;
    dones  = 0;
  endtask

  initial begin
    pix_t all500;
    logic signed [W-1:0] exp0;
    bus.i_feature_valid = 1'b0;
    bus.i_features      = '0;
    for (int m = 0; m < N; m++) all500[m] = 16'd500;
`ifdef POOL_RELU_EN
    exp0 = 16'sd0;
`else
    exp0 = -16'sd1;
`endif

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (bus.o_feature_valid === 1'b0) else begin errors++; $error("FAIL rst_valid got %b exp 0", bus.o_feature_valid); end
    checks++;
    assert (bus.o_frame_done === 1'b0) else begin errors++; $error("FAIL rst_done got %b exp 0", bus.o_frame_done); end
    checks++;
    assert (bus.o_features === '0) else begin errors++; $error("FAIL rst_features got %h exp 0", bus.o_features); end
    rst = 1'b0;
    idle(20);
    checks++;
    assert (bus.o_features === '0) else begin errors++; $error("FAIL idle_features got %h exp 0", bus.o_features); end
    drain_and_count("idle", 0, 0);

    // Constant 40 frame, back to back
    send_frame(0, 0, IW * IH);
    drain_and_count("const40", POOLED, 1);

    // Max at a different corner per map
    send_frame(2, 0, IW * IH);
    drain_and_count("corner", POOLED, 1);
    checks++;
    assert (bus.o_features === all500) else begin errors++; $error("FAIL corner_last got %h exp %h", bus.o_features, all500); end

    // Signed compare on map 0
    send_frame(3, 0, IW * IH);
    drain_and_count("signed", POOLED, 1);
    checks++;
    assert ($signed(bus.o_features[0]) === exp0)
      else begin errors++; $error("FAIL signed_map0 got %0d exp %0d", $signed(bus.o_features[0]), exp0); end

    // Gapped constant frame and gapped random frame
    send_frame(0, 5, IW * IH);
    drain_and_count("gapped40", POOLED, 1);
    send_frame(4, 3, IW * IH);
    drain_and_count("random", POOLED, 1);

    // Mid-frame reset, then a full frame of 41
    send_frame(0, 0, 300);
    idle(2);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    checks++;
    assert (bus.o_features === '0) else begin errors++; $error("FAIL midrst_features got %h exp 0", bus.o_features); end
    rst = 1'b0;
    pulses = 0;
    dones  = 0;
    send_frame(1, 0, IW * IH);
    drain_and_count("after_rst", POOLED, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
